// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer.
//   - opcode encodings carried on cmd_op / alu_sel
//   - sequencer FSM state encoding
//   - packed command word stored in the command FIFO and instruction register
package alu_pkg;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_SUB   = 3'b001;
   localparam logic [2:0] OP_AND   = 3'b010;
   localparam logic [2:0] OP_OR    = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_LOADI = 3'b101;
   localparam logic [2:0] OP_READ  = 3'b110;
   localparam logic [2:0] OP_RSVD  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] dst;
      logic [1:0] src_a;
      logic [1:0] src_b;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // Opcodes that go through the external ALU (the only ones that may
   // appear on alu_sel).
   function automatic logic is_alu_op(input logic [2:0] op);
      return (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for buffered commands.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push, din   - write request / data; ignored while full
//   pop, dout   - read request / head-of-queue data (valid while !empty)
//   full, empty - status, derived directly from the registered pointers
module alu_cmd_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   // when the index bits match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a 2-bit combinational ALU.
// Commands are queued in a FIFO, executed one at a time against a 4 x 2-bit
// register file, and each produces exactly one response.
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_op, cmd_dst, cmd_src_a, cmd_src_b - command stream
//   alu_a, alu_b, alu_sel          - ALU operand/opcode drive
//   alu_result, alu_carry          - combinational ALU return
//   rsp_valid/rsp_ready, rsp_data, rsp_carry, rsp_err - response stream
//   busy                           - work queued or in flight
//
// Both streams use plain valid/ready: a transfer happens on a rising edge
// where valid && ready are both high; the sender keeps its payload stable
// while valid is high and ready is low, and never withdraws valid early.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_dst,
   input  logic [1:0] cmd_src_a,
   input  logic [1:0] cmd_src_b,
   output logic [1:0] alu_a,
   output logic [1:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [1:0] alu_result,
   input  logic       alu_carry,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [1:0] rsp_data,
   output logic       rsp_carry,
   output logic       rsp_err,
   output logic       busy
);

   state_t          state;
   state_t          state_nxt;
   cmd_t            fifo_din;
   cmd_t            fifo_dout;
   cmd_t            ir;
   logic            fifo_full;
   logic            fifo_empty;
   logic            fifo_pop;
   logic [3:0][1:0] rf;
   logic [1:0]      res_data;
   logic            res_carry;
   logic            res_err;
   logic            res_wr;

   always_comb begin
      fifo_din       = '0;
      fifo_din.op    = cmd_op;
      fifo_din.dst   = cmd_dst;
      fifo_din.src_a = cmd_src_a;
      fifo_din.src_b = cmd_src_b;
   end

   alu_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Combinational from the registered FIFO pointers, so ready drops in the
   // same cycle the FIFO fills.
   assign cmd_ready = !fifo_full;
   assign rsp_valid = (state == ST_RESP);
   assign busy      = !fifo_empty || (state != ST_IDLE);

   // Next state and FIFO pop
   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ALU drive: only during EXEC of an arithmetic/logic op, otherwise parked
   // at zero so alu_sel never shows LOADI/READ/reserved encodings.
   always_comb begin
      alu_a   = 2'b00;
      alu_b   = 2'b00;
      alu_sel = OP_ADD;
      if (state == ST_EXEC && is_alu_op(ir.op)) begin
         alu_a   = rf[ir.src_a];
         alu_b   = rf[ir.src_b];
         alu_sel = ir.op;
      end
   end

   // Result selection for the command in the instruction register
   always_comb begin
      res_data  = 2'b00;
      res_carry = 1'b0;
      res_err   = 1'b0;
      res_wr    = 1'b0;
      case (ir.op)
         OP_ADD, OP_SUB: begin
            res_data  = alu_result;
            res_carry = alu_carry;
            res_wr    = 1'b1;
         end
         OP_AND, OP_OR, OP_XOR: begin
            // Logic ops report no carry regardless of the ALU's carry line.
            res_data = alu_result;
            res_wr   = 1'b1;
         end
         OP_LOADI: begin
            res_data = ir.src_b;
            res_wr   = 1'b1;
         end
         OP_READ: res_data = rf[ir.src_a];
         default: res_err  = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         ir        <= '0;
         rf        <= '0;
         rsp_data  <= 2'b00;
         rsp_carry <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (fifo_pop) ir <= fifo_dout;
         if (state == ST_EXEC) begin
            rsp_data  <= res_data;
            rsp_carry <= res_carry;
            rsp_err   <= res_err;
            if (res_wr) rf[ir.dst] <= res_data;
         end
      end
   end

endmodule
